// File: rtl/pixel_pack_frame_writer.sv
// Packs an 8-bit pixel stream into 32-bit words and writes whole frames into
// ping-pong banks of the frame memory over Avalon-MM, flagging each finished bank.
module pixel_pack_frame_writer #(
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 19200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic              avm_clken,
  output logic              frame_done,
  output logic              done_bank,
  output logic [15:0]       done_words,
  output logic              overflow,
  output logic              sop_err
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [ADDR_W-1:0] BANK0_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BANK1_BASE  = ADDR_W'(BASE_ADDR + FRAME_WORDS);
  localparam logic [15:0]       FRAME_LIMIT = 16'(FRAME_WORDS);

  generate
    if (BASE_ADDR < 0 || FRAME_WORDS < 1 || FRAME_WORDS > 65535 ||
        BASE_ADDR + 2 * FRAME_WORDS > 51200 ||
        (ADDR_W < 31 && (1 << ADDR_W) < BASE_ADDR + 2 * FRAME_WORDS)) begin : g_bad_cfg
      $error("pixel_pack_frame_writer: bank layout does not fit the 51200-word memory");
    end
  endgenerate

  state_t             r_state;
  logic               r_bank;
  logic [1:0]         r_lane;
  logic [31:0]        r_data;
  logic [15:0]        r_word_idx;
  logic               r_eop_pend;
  logic               r_ready;
  logic [ADDR_W-1:0]  r_addr;
  logic [3:0]         r_be;
  logic               r_write;
  logic [31:0]        r_wdata;
  logic               r_frame_done;
  logic               r_done_bank;
  logic [15:0]        r_done_words;
  logic               r_overflow;
  logic               r_sop_err;

  logic               w_beat;
  logic               w_take;
  logic [1:0]         w_lane;
  logic [31:0]        w_base;
  logic [15:0]        w_idx;
  logic               w_full;
  logic               w_flush;
  logic [31:0]        w_packed;
  logic [3:0]         w_be;
  logic [ADDR_W-1:0]  w_wr_addr;

  // A start-of-frame beat restarts packing from lane 0 of word 0, dropping any partial word.
  always_comb begin
    w_beat    = in_valid & r_ready;
    w_take    = w_beat & (((r_state == IDLE) & in_sop) | ((r_state == FILL) & ~r_eop_pend));
    w_lane    = in_sop ? 2'd0 : r_lane;
    w_base    = in_sop ? 32'd0 : r_data;
    w_idx     = in_sop ? 16'd0 : r_word_idx;
    w_full    = (w_idx >= FRAME_LIMIT);
    w_flush   = (w_lane == 2'd3) | in_eop;
    w_packed  = w_base | ({24'd0, in_data} << {w_lane, 3'b000});
    w_wr_addr = (r_bank ? BANK1_BASE : BANK0_BASE) + ADDR_W'(w_idx);
    w_be      = 4'b1111;
    case (w_lane)
      2'd0:    w_be = 4'b0001;
      2'd1:    w_be = 4'b0011;
      2'd2:    w_be = 4'b0111;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_bank       <= 1'b0;
      r_lane       <= 2'd0;
      r_data       <= 32'd0;
      r_word_idx   <= 16'd0;
      r_eop_pend   <= 1'b0;
      r_ready      <= 1'b0;
      r_addr       <= '0;
      r_be         <= 4'd0;
      r_write      <= 1'b0;
      r_wdata      <= 32'd0;
      r_frame_done <= 1'b0;
      r_done_bank  <= 1'b0;
      r_done_words <= 16'd0;
      r_overflow   <= 1'b0;
      r_sop_err    <= 1'b0;
    end else begin
      r_write      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_beat && in_sop) r_state <= FILL;
        end
        FILL: begin
          // The eop word goes out first; the frame is reported one cycle later.
          if (r_eop_pend) begin
            r_state      <= DONE;
            r_ready      <= 1'b0;
            r_eop_pend   <= 1'b0;
            r_frame_done <= 1'b1;
            r_done_bank  <= r_bank;
            r_done_words <= r_word_idx;
          end else if (w_beat && in_sop) begin
            r_sop_err <= 1'b1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_ready    <= 1'b1;
          r_bank     <= ~r_bank;
          r_word_idx <= 16'd0;
          r_lane     <= 2'd0;
          r_data     <= 32'd0;
        end
        default: r_state <= IDLE;
      endcase

      if (w_take) begin
        r_word_idx <= w_idx;
        r_lane     <= w_lane;
        if (in_eop) r_eop_pend <= 1'b1;
        // Once the bank is full, pixels are swallowed so nothing lands in the other bank.
        if (w_full) begin
          r_overflow <= 1'b1;
          r_data     <= w_base;
        end else if (w_flush) begin
          r_write    <= 1'b1;
          r_addr     <= w_wr_addr;
          r_wdata    <= w_packed;
          r_be       <= w_be;
          r_data     <= 32'd0;
          r_lane     <= 2'd0;
          r_word_idx <= w_idx + 16'd1;
        end else begin
          r_data <= w_packed;
          r_lane <= w_lane + 2'd1;
        end
      end
    end
  end

  assign in_ready       = r_ready;
  assign avm_address    = r_addr;
  assign avm_byteenable = r_be;
  assign avm_chipselect = r_write;
  assign avm_write      = r_write;
  assign avm_writedata  = r_wdata;
  assign avm_clken      = 1'b1;
  assign frame_done     = r_frame_done;
  assign done_bank      = r_done_bank;
  assign done_words     = r_done_words;
  assign overflow       = r_overflow;
  assign sop_err        = r_sop_err;

endmodule

// File: tb/tb_pixel_pack_frame_writer.sv
// Directed bench for pixel_pack_frame_writer: a full-size instance plus a
// two-word-bank instance for the overflow case, selected by 'sel'.
module tb_pixel_pack_frame_writer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_sop;
   logic        in_eop;
   logic        sel;

   logic        bReady, bCs, bWr, bClken, bDone, bDoneBank, bOvf, bSopErr;
   logic [15:0] bAddr, bDoneWords;
   logic [3:0]  bBe;
   logic [31:0] bData;
   logic        sReady, sCs, sWr, sClken, sDone, sDoneBank, sOvf, sSopErr;
   logic [15:0] sAddr, sDoneWords;
   logic [3:0]  sBe;
   logic [31:0] sData;

   logic        bigValid, smallValid;
   logic        rdy, mWr, mDone, mDoneBank, mOvf, mSopErr;
   logic [15:0] mAddr, mDoneWords;
   logic [3:0]  mBe;
   logic [31:0] mData;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cfgBad = 0;

   typedef struct {logic [15:0] addr; logic [31:0] data; logic [3:0] be; int cyc;} wrT;
   typedef struct {logic bank; logic [15:0] words; int cyc;} doneT;
   wrT   wrLog[$];
   doneT doneLog[$];
   int   beatCyc[$];

   assign bigValid   = in_valid & ~sel;
   assign smallValid = in_valid & sel;

   pixel_pack_frame_writer dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(bigValid),
      .in_ready(bReady), .in_sop(in_sop), .in_eop(in_eop),
      .avm_address(bAddr), .avm_byteenable(bBe), .avm_chipselect(bCs),
      .avm_write(bWr), .avm_writedata(bData), .avm_clken(bClken),
      .frame_done(bDone), .done_bank(bDoneBank), .done_words(bDoneWords),
      .overflow(bOvf), .sop_err(bSopErr)
   );

   pixel_pack_frame_writer #(.ADDR_W(16), .BASE_ADDR(0), .FRAME_WORDS(2)) dutSmall (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(smallValid),
      .in_ready(sReady), .in_sop(in_sop), .in_eop(in_eop),
      .avm_address(sAddr), .avm_byteenable(sBe), .avm_chipselect(sCs),
      .avm_write(sWr), .avm_writedata(sData), .avm_clken(sClken),
      .frame_done(sDone), .done_bank(sDoneBank), .done_words(sDoneWords),
      .overflow(sOvf), .sop_err(sSopErr)
   );

   assign rdy        = sel ? sReady     : bReady;
   assign mWr        = sel ? sWr        : bWr;
   assign mAddr      = sel ? sAddr      : bAddr;
   assign mData      = sel ? sData      : bData;
   assign mBe        = sel ? sBe        : bBe;
   assign mDone      = sel ? sDone      : bDone;
   assign mDoneBank  = sel ? sDoneBank  : bDoneBank;
   assign mDoneWords = sel ? sDoneWords : bDoneWords;
   assign mOvf       = sel ? sOvf       : bOvf;
   assign mSopErr    = sel ? sSopErr    : bSopErr;

   // Free-running clock and cycle count used to time writes against accepted beats.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Mid-cycle monitor: logs writes, frame-done pulses and accepted beats of the selected instance.
   always @(negedge clk) begin
      wrT   w;
      doneT d;
      if (mWr === 1'b1) begin
         w.addr = mAddr; w.data = mData; w.be = mBe; w.cyc = cyc;
         wrLog.push_back(w);
      end
      if (mDone === 1'b1) begin
         d.bank = mDoneBank; d.words = mDoneWords; d.cyc = cyc;
         doneLog.push_back(d);
      end
      if (in_valid === 1'b1 && rdy === 1'b1) beatCyc.push_back(cyc);
      if (bCs !== bWr || sCs !== sWr || bClken !== 1'b1 || sClken !== 1'b1) cfgBad++;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one pixel and holds it until the instance accepts it; returns 1 time unit after that edge.
   task automatic applyStimulus(input logic [7:0] d, input logic s, input logic e);
      bit ok = 1'b0;
      in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
      for (int t = 0; t < 16; t++) begin
         @(negedge clk);
         if (rdy === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!ok) checkOutput("readyTimeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clearLogs();
      wrLog.delete();
      doneLog.delete();
      beatCyc.delete();
   endtask

   task automatic checkWrite(input string tag, input int idx, input logic [15:0] a,
                             input logic [31:0] d, input logic [3:0] be);
      wrT w;
      w.addr = 'x; w.data = 'x; w.be = 'x; w.cyc = -1;
      if (idx < wrLog.size()) w = wrLog[idx];
      checkOutput({tag, ".addr"}, 32'(w.addr), 32'(a));
      checkOutput({tag, ".data"}, w.data, d);
      checkOutput({tag, ".be"}, 32'(w.be), 32'(be));
   endtask

   task automatic checkDone(input string tag, input logic bank, input logic [15:0] words);
      doneT d;
      d.bank = 'x; d.words = 'x; d.cyc = -1;
      checkOutput({tag, ".count"}, doneLog.size(), 32'd1);
      if (doneLog.size() > 0) d = doneLog[0];
      checkOutput({tag, ".bank"}, 32'(d.bank), 32'(bank));
      checkOutput({tag, ".words"}, 32'(d.words), 32'(words));
   endtask

   function automatic int wrCyc(input int idx);
      return (idx < wrLog.size()) ? wrLog[idx].cyc : -1000;
   endfunction

   function automatic int beatAt(input int idx);
      return (idx < beatCyc.size()) ? beatCyc[idx] : -2000;
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".ctl"}, 32'({bWr, bCs, bBe, bDone, bDoneBank, bOvf, bSopErr, bReady, bClken}), 32'd1);
      checkOutput({tag, ".addr"}, 32'(bAddr), 32'd0);
      checkOutput({tag, ".data"}, bData, 32'd0);
      checkOutput({tag, ".doneWords"}, 32'(bDoneWords), 32'd0);
   endtask

   initial begin
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'd0; sel = 1'b0;

      // Power-on reset, then release on a falling edge; ready must wait for the next rising edge.
      #2 reset_n = 1'b0;
      #1 checkResetOutputs("porReset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1 checkOutput("readyAfterRelease", 32'(bReady), 32'd0);
      @(posedge clk);
      #1 checkOutput("readyFirstEdge", 32'(bReady), 32'd1);

      // Frame 1: eight back-to-back pixels into bank 0.
      clearLogs();
      for (int i = 1; i <= 8; i++) applyStimulus(8'(i), i == 1, i == 8);
      idle(4);
      checkOutput("f1.wrCount", wrLog.size(), 32'd2);
      checkWrite("f1.w0", 0, 16'h0000, 32'h04030201, 4'hF);
      checkWrite("f1.w1", 1, 16'h0001, 32'h08070605, 4'hF);
      checkOutput("f1.lat0", wrCyc(0), beatAt(3) + 1);
      checkOutput("f1.lat1", wrCyc(1), beatAt(7) + 1);
      checkOutput("f1.backToBack", beatAt(7) - beatAt(0), 32'd7);
      checkDone("f1.done", 1'b0, 16'd2);
      checkOutput("f1.doneAfterWrite", (doneLog.size() > 0) ? doneLog[0].cyc : -1, wrCyc(1) + 1);

      // Frame 2: five pixels into bank 1, last word partial.
      clearLogs();
      for (int i = 0; i < 5; i++) applyStimulus(8'(8'h0A + i), i == 0, i == 4);
      idle(4);
      checkOutput("f2.wrCount", wrLog.size(), 32'd2);
      checkWrite("f2.w0", 0, 16'h4B00, 32'h0D0C0B0A, 4'hF);
      checkWrite("f2.w1", 1, 16'h4B01, 32'h0000000E, 4'h1);
      checkDone("f2.done", 1'b1, 16'd2);

      // Frame 3: single pixel with sop and eop together, back in bank 0.
      clearLogs();
      applyStimulus(8'h5A, 1'b1, 1'b1);
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      checkOutput("f3.writeCycle", 32'({bWr, bReady, bDone}), 32'b110);
      checkOutput("f3.addr", 32'(bAddr), 32'd0);
      checkOutput("f3.data", bData, 32'h0000005A);
      checkOutput("f3.be", 32'(bBe), 32'h1);
      @(posedge clk); #1;
      checkOutput("f3.doneCycle", 32'({bWr, bReady, bDone}), 32'b001);
      checkOutput("f3.doneBankWords", 32'({bDoneBank, bDoneWords}), 32'h00001);
      @(posedge clk); #1;
      checkOutput("f3.afterDone", 32'({bReady, bDone}), 32'b10);
      checkOutput("f3.wordsHeld", 32'(bDoneWords), 32'd1);
      idle(2);
      checkOutput("f3.wrCount", wrLog.size(), 32'd1);

      // Reset mid-frame after six pixels in bank 1.
      clearLogs();
      for (int i = 1; i <= 6; i++) applyStimulus(8'(i), i == 1, 1'b0);
      in_valid = 1'b0; in_sop = 1'b0;
      reset_n = 1'b0;
      #1 checkResetOutputs("midReset");
      @(negedge clk);
      #1 reset_n = 1'b1;
      idle(4);
      checkOutput("midReset.wrCount", wrLog.size(), 32'd1);
      checkWrite("midReset.w0", 0, 16'h4B00, 32'h04030201, 4'hF);
      checkOutput("midReset.noDone", doneLog.size(), 32'd0);
      checkOutput("midReset.ready", 32'(bReady), 32'd1);

      // Restart inside a frame: partial word dropped, new frame lands at bank 0 word 0.
      clearLogs();
      applyStimulus(8'h01, 1'b1, 1'b0);
      applyStimulus(8'h02, 1'b0, 1'b0);
      applyStimulus(8'h03, 1'b0, 1'b0);
      checkOutput("restart.sopErrBefore", 32'(bSopErr), 32'd0);
      applyStimulus(8'h10, 1'b1, 1'b0);
      checkOutput("restart.sopErrSet", 32'(bSopErr), 32'd1);
      applyStimulus(8'h11, 1'b0, 1'b0);
      applyStimulus(8'h12, 1'b0, 1'b0);
      applyStimulus(8'h13, 1'b0, 1'b1);
      idle(4);
      checkOutput("restart.wrCount", wrLog.size(), 32'd1);
      checkWrite("restart.w0", 0, 16'h0000, 32'h13121110, 4'hF);
      checkDone("restart.done", 1'b0, 16'd1);
      checkOutput("restart.flags", 32'({bSopErr, bOvf}), 32'b10);

      // Full-cycle reset, then an eop beat with no open frame must be ignored.
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      idle(2);
      clearLogs();
      applyStimulus(8'h77, 1'b0, 1'b1);
      idle(4);
      checkOutput("strayEop.wrCount", wrLog.size(), 32'd0);
      checkOutput("strayEop.doneCount", doneLog.size(), 32'd0);
      checkOutput("strayEop.flags", 32'({bSopErr, bOvf, bReady}), 32'b001);

      // Gapped input: valid every other cycle, same words as frame 1.
      clearLogs();
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(8'(i), i == 1, i == 8);
         if (i != 8) idle(1);
      end
      idle(4);
      checkOutput("gap.wrCount", wrLog.size(), 32'd2);
      checkWrite("gap.w0", 0, 16'h0000, 32'h04030201, 4'hF);
      checkWrite("gap.w1", 1, 16'h0001, 32'h08070605, 4'hF);
      checkOutput("gap.spacing", beatAt(1) - beatAt(0), 32'd2);
      checkOutput("gap.lat0", wrCyc(0), beatAt(3) + 1);
      checkOutput("gap.lat1", wrCyc(1), beatAt(7) + 1);
      checkDone("gap.done", 1'b0, 16'd2);

      // Overflow on the two-word instance: twelve pixels, only eight written.
      sel = 1'b1;
      clearLogs();
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(8'(8'h20 + i), i == 1, i == 12);
         if (i == 8) checkOutput("ovf.clearAfter8", 32'(mOvf), 32'd0);
         if (i == 9) checkOutput("ovf.setAfter9", 32'(mOvf), 32'd1);
      end
      idle(4);
      checkOutput("ovf.wrCount", wrLog.size(), 32'd2);
      checkWrite("ovf.w0", 0, 16'h0000, 32'h24232221, 4'hF);
      checkWrite("ovf.w1", 1, 16'h0001, 32'h28272625, 4'hF);
      checkDone("ovf.done", 1'b0, 16'd2);
      checkOutput("ovf.sticky", 32'({mOvf, mSopErr}), 32'b10);
      checkOutput("ovf.bigUntouched", 32'(bOvf), 32'd0);
      sel = 1'b0;

      checkOutput("chipselEqWriteClken", cfgBad, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
